freq_sweep_ctrl: RTL and testbench
==================================

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have reset RSTN, asynchronous, active-low, and clock clk_100MHz.
REQ-002 Ports (name direction width meaning), in this order:
  clk_100MHz  in  1  system clock
  RSTN  in  1  async active-low reset
  o_Rx_Four_Bytes  in  32  command word from the UART receiver
  o_Rx_DV  in  1  command valid, 1-cycle pulse
  period_tick  in  1  1-cycle pulse from the tone generator at each output-period boundary
  freq_divider  out  16  divider currently applied to the generator
  div_update  out  1  1-cycle pulse when freq_divider changes
  sweep_active  out  1  high while in a sweep state
  cmd_err  out  1  1-cycle pulse when a command is rejected
REQ-003 Command word fields: [31:28] opcode, [15:0] value; bits [27:16] are ignored.

Function
REQ-004 Opcodes:
  0x1 SET: fixed divider = value.
  0x2 PRESET: value 1/2/3 -> 1253/1250/1246; any other value -> 1250.
  0x3 MIN: write min.
  0x4 MAX: write max.
  0x5 STEP: write step.
  0x6 DWELL: write dwell (periods per step).
  0x7 START.
  0x8 STOP.
  Other opcodes -> cmd_err.
REQ-005 SET, MIN, MAX, STEP or DWELL with value 0 SHALL be rejected: cmd_err pulses and no state changes.
REQ-006 The block SHALL never change freq_divider except on a clk edge where period_tick=1 and a staged (pending) value exists; at that edge freq_divider <= pending, the pending flag clears and div_update pulses next cycle.
REQ-007 Staging rules: a new staged value overwrites any older unapplied one (last wins); staging a value equal to freq_divider still produces div_update when it is applied.
REQ-008 States:
  IDLE: fixed divider.
  DWELL: counting period_ticks.
  STEP: one cycle, computes the next divider.
  sweep_active = 1 in DWELL and STEP.
REQ-009 SET/PRESET in any state: stage the value, go to IDLE (aborts a sweep).
REQ-010 START with min > max SHALL pulse cmd_err and change nothing.
REQ-011 A valid START SHALL stage min, set dir=up, clear dwell_cnt and enter DWELL; START during a sweep restarts the sweep.
REQ-012 STOP: go to IDLE; freq_divider holds its last applied value; any pending value is still applied at the next tick.
REQ-013 DWELL: every period_tick increments dwell_cnt (16-bit); on the tick where dwell_cnt = dwell-1, go to STEP and clear dwell_cnt.
REQ-014 STEP, direction up:
  next = cur+step, computed at 17 bits.
  If next >= max: stage max, set dir=down.
  Otherwise stage next.
  Return to DWELL.
REQ-015 STEP, direction down:
  If cur <= min+step (17-bit): stage min, set dir=up.
  Otherwise stage cur-step.
  Return to DWELL.
REQ-016 cur SHALL be the most recently staged sweep value, not the applied value.
REQ-017 MIN/MAX/STEP/DWELL writes during a sweep take effect at the next STEP or dwell compare; the current divider is unaffected.
REQ-018 Simultaneous events:
  o_Rx_DV with a dwell-expiry tick: the command wins and the step is discarded.
  o_Rx_DV with a tick applying pending: the apply happens first, and the command's staged value waits for the next tick.
REQ-019 Configuration registers SHALL persist across STOP and are cleared only by reset.

Reset
REQ-020 Reset values:
  freq_divider = 1250
  min = 1246, max = 1253, step = 1, dwell = 40000
  dir = up, dwell_cnt = 0, pending flag = 0
  state = IDLE
  div_update, sweep_active, cmd_err = 0
REQ-021 Reset asserted mid-sweep SHALL return immediately to these values, with no div_update pulse on release.

Structure
REQ-022 A shared package SHALL hold:
  opcode constants
  preset divider constants 1253/1250/1246
  reset defaults
  the state enum
REQ-023 The sweep next-value computation (REQ-014/015) SHALL be a combinational sub-module sweep_step_calc (inputs cur, step, min, max, dir; outputs next, dir_next).

Verification
REQ-024 PRESET value=1, then tick -> freq_divider=1253 with one div_update pulse; no change occurs before the tick.
REQ-025 MIN=1246, MAX=1253, STEP=3, DWELL=2, START, ticks -> applied sequence 1246, 1249, 1252, 1253, 1250, 1247, 1246, 1249, each held 2 ticks (clamp and reverse at both ends).
REQ-026 MIN=1300, MAX=1200, START -> cmd_err pulse, state stays IDLE, freq_divider unchanged; STEP=0 -> cmd_err.
REQ-027 During the sweep, STOP issued in the same cycle as a dwell-expiry tick -> no new step staged, sweep_active=0, divider holds.
REQ-028 Two SETs (1400 then 1500) before any tick -> a single update to 1500; RSTN low mid-sweep -> freq_divider=1250 and all outputs at reset values.

Source files
------------

// File: rtl/freq_sweep_ctrl_pkg.sv
// Shared constants, reset defaults and state type for the tone-divider sweep controller.
package freq_sweep_ctrl_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_SET    = 4'h1;
  localparam logic [3:0] OP_PRESET = 4'h2;
  localparam logic [3:0] OP_MIN    = 4'h3;
  localparam logic [3:0] OP_MAX    = 4'h4;
  localparam logic [3:0] OP_STEP   = 4'h5;
  localparam logic [3:0] OP_DWELL  = 4'h6;
  localparam logic [3:0] OP_START  = 4'h7;
  localparam logic [3:0] OP_STOP   = 4'h8;

  localparam logic [DATA_W-1:0] DIV_PRESET_1 = 16'd1253;
  localparam logic [DATA_W-1:0] DIV_PRESET_2 = 16'd1250;
  localparam logic [DATA_W-1:0] DIV_PRESET_3 = 16'd1246;

  localparam logic [DATA_W-1:0] RST_DIV   = 16'd1250;
  localparam logic [DATA_W-1:0] RST_MIN   = 16'd1246;
  localparam logic [DATA_W-1:0] RST_MAX   = 16'd1253;
  localparam logic [DATA_W-1:0] RST_STEP  = 16'd1;
  localparam logic [DATA_W-1:0] RST_DWELL = 16'd40000;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_STEP  = 2'd2
  } sweep_state_t;

  // Unknown preset selectors fall back to the nominal divider.
  function automatic logic [DATA_W-1:0] preset_div(input logic [DATA_W-1:0] sel);
    case (sel)
      16'd1:   return DIV_PRESET_1;
      16'd2:   return DIV_PRESET_2;
      16'd3:   return DIV_PRESET_3;
      default: return DIV_PRESET_2;
    endcase
  endfunction

endpackage

// File: rtl/freq_sweep_ctrl_step.sv
// Combinational triangle-sweep next value: clamps at max/min and reverses direction there.
module sweep_step_calc
  import freq_sweep_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] min,
  input  logic [DATA_W-1:0] max,
  input  logic              dir,
  output logic [DATA_W-1:0] next,
  output logic              dir_next
);

  logic [DATA_W:0] w_up_sum;
  logic [DATA_W:0] w_dn_lim;

  // One extra bit so neither the up sum nor the down limit can wrap.
  assign w_up_sum = {1'b0, cur} + {1'b0, step};
  assign w_dn_lim = {1'b0, min} + {1'b0, step};

  always_comb begin
    next     = cur;
    dir_next = dir;
    if (dir == DIR_UP) begin
      if (w_up_sum >= {1'b0, max}) begin
        next     = max;
        dir_next = DIR_DOWN;
      end else begin
        next = w_up_sum[DATA_W-1:0];
      end
    end else begin
      if ({1'b0, cur} <= w_dn_lim) begin
        next     = min;
        dir_next = DIR_UP;
      end else begin
        next = cur - step;
      end
    end
  end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// UART-commanded tone divider controller: fixed/preset dividers and min..max triangle sweeps,
// with every divider change deferred to a generator period boundary.
module freq_sweep_ctrl
  import freq_sweep_ctrl_pkg::*;
(
  input  logic              clk_100MHz,
  input  logic              RSTN,
  input  logic [31:0]       o_Rx_Four_Bytes,
  input  logic              o_Rx_DV,
  input  logic              period_tick,
  output logic [DATA_W-1:0] freq_divider,
  output logic              div_update,
  output logic              sweep_active,
  output logic              cmd_err
);

  sweep_state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_freq_divider, r_pending_val, r_cur;
  logic [DATA_W-1:0] r_min, r_max, r_step, r_dwell, r_dwell_cnt;
  logic              r_pending, r_dir, r_div_update, r_cmd_err;

  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_val;
  logic              w_val_zero, w_apply, w_dwell_exp, w_unused_bits;
  logic [DATA_W-1:0] w_calc_next;
  logic              w_calc_dir;

  logic              w_stage, w_dir_nxt, w_err;
  logic [DATA_W-1:0] w_stage_val, w_cur_nxt, w_cnt_nxt;
  logic [DATA_W-1:0] w_min_nxt, w_max_nxt, w_step_nxt, w_dwell_nxt;

  assign w_op          = o_Rx_Four_Bytes[31:28];
  assign w_val         = o_Rx_Four_Bytes[15:0];
  assign w_unused_bits = ^o_Rx_Four_Bytes[27:16];
  assign w_val_zero    = (w_val == '0);
  assign w_apply       = period_tick & r_pending;
  assign w_dwell_exp   = (r_state == ST_DWELL) & period_tick &
                         (r_dwell_cnt == r_dwell - 16'd1);

  sweep_step_calc u_step (
    .cur      (r_cur),
    .step     (r_step),
    .min      (r_min),
    .max      (r_max),
    .dir      (r_dir),
    .next     (w_calc_next),
    .dir_next (w_calc_dir)
  );

  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stage     = 1'b0;
    w_stage_val = r_pending_val;
    w_cur_nxt   = r_cur;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_dwell_cnt;
    w_min_nxt   = r_min;
    w_max_nxt   = r_max;
    w_step_nxt  = r_step;
    w_dwell_nxt = r_dwell;
    w_err       = 1'b0;

    case (r_state)
      ST_DWELL: begin
        if (w_dwell_exp) begin
          w_cnt_nxt = '0;
          // A command arriving with the expiry tick discards this step.
          if (!o_Rx_DV) w_state_nxt = ST_STEP;
        end else if (period_tick) begin
          w_cnt_nxt = r_dwell_cnt + 16'd1;
        end
      end
      ST_STEP: begin
        w_stage     = 1'b1;
        w_stage_val = w_calc_next;
        w_cur_nxt   = w_calc_next;
        w_dir_nxt   = w_calc_dir;
        w_state_nxt = ST_DWELL;
      end
      default: ;
    endcase

    if (o_Rx_DV) begin
      case (w_op)
        OP_SET: begin
          if (w_val_zero) w_err = 1'b1;
          else begin
            w_stage     = 1'b1;
            w_stage_val = w_val;
            w_state_nxt = ST_IDLE;
          end
        end
        OP_PRESET: begin
          w_stage     = 1'b1;
          w_stage_val = preset_div(w_val);
          w_state_nxt = ST_IDLE;
        end
        OP_MIN:   if (w_val_zero) w_err = 1'b1; else w_min_nxt   = w_val;
        OP_MAX:   if (w_val_zero) w_err = 1'b1; else w_max_nxt   = w_val;
        OP_STEP:  if (w_val_zero) w_err = 1'b1; else w_step_nxt  = w_val;
        OP_DWELL: if (w_val_zero) w_err = 1'b1; else w_dwell_nxt = w_val;
        OP_START: begin
          if (r_min > r_max) w_err = 1'b1;
          else begin
            w_stage     = 1'b1;
            w_stage_val = r_min;
            w_cur_nxt   = r_min;
            w_dir_nxt   = DIR_UP;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DWELL;
          end
        end
        OP_STOP: w_state_nxt = ST_IDLE;
        default: w_err = 1'b1;
      endcase
    end
  end

  // The apply uses the old pending value, so a value staged on the same edge waits a tick.
  always_ff @(posedge clk_100MHz or negedge RSTN) begin
    if (!RSTN) begin
      r_freq_divider <= RST_DIV;
      r_pending_val  <= RST_DIV;
      r_pending      <= 1'b0;
      r_cur          <= RST_DIV;
      r_dir          <= DIR_UP;
      r_dwell_cnt    <= '0;
      r_min          <= RST_MIN;
      r_max          <= RST_MAX;
      r_step         <= RST_STEP;
      r_dwell        <= RST_DWELL;
      r_div_update   <= 1'b0;
      r_cmd_err      <= 1'b0;
    end else begin
      if (w_apply) r_freq_divider <= r_pending_val;
      if (w_stage) begin
        r_pending     <= 1'b1;
        r_pending_val <= w_stage_val;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      r_cur        <= w_cur_nxt;
      r_dir        <= w_dir_nxt;
      r_dwell_cnt  <= w_cnt_nxt;
      r_min        <= w_min_nxt;
      r_max        <= w_max_nxt;
      r_step       <= w_step_nxt;
      r_dwell      <= w_dwell_nxt;
      r_div_update <= w_apply;
      r_cmd_err    <= w_err;
    end
  end

  assign freq_divider = r_freq_divider;
  assign div_update   = r_div_update;
  assign cmd_err      = r_cmd_err;
  assign sweep_active = (r_state != ST_IDLE);

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Scoreboard bench for freq_sweep_ctrl: expected dividers queued with stimulus, popped on div_update.
`timescale 1ns/1ps
module tb_freq_sweep_ctrl;

  logic        clk_100MHz = 1'b0;
  logic        RSTN;
  logic [31:0] o_Rx_Four_Bytes;
  logic        o_Rx_DV;
  logic        period_tick;
  logic [15:0] freq_divider;
  logic        div_update;
  logic        sweep_active;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk_100MHz = ~clk_100MHz;

  freq_sweep_ctrl dut (
    .clk_100MHz      (clk_100MHz),
    .RSTN            (RSTN),
    .o_Rx_Four_Bytes (o_Rx_Four_Bytes),
    .o_Rx_DV         (o_Rx_DV),
    .period_tick     (period_tick),
    .freq_divider    (freq_divider),
    .div_update      (div_update),
    .sweep_active    (sweep_active),
    .cmd_err         (cmd_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk_100MHz) begin
    if (RSTN && div_update) begin
      upd_cnt++;
      chk("upd_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("upd_value", 32'(freq_divider), 32'(exp_q.pop_front()));
    end
    if (RSTN && cmd_err) err_cnt++;
  end

  task automatic send(input logic [3:0] op, input logic [15:0] val);
    @(negedge clk_100MHz);
    o_Rx_Four_Bytes = {op, 12'hA5C, val};
    o_Rx_DV = 1'b1;
    @(negedge clk_100MHz);
    o_Rx_DV = 1'b0;
    repeat (2) @(negedge clk_100MHz);
  endtask

  task automatic tick();
    @(negedge clk_100MHz);
    period_tick = 1'b1;
    @(negedge clk_100MHz);
    period_tick = 1'b0;
    repeat (3) @(negedge clk_100MHz);
  endtask

  task automatic send_tick(input logic [3:0] op, input logic [15:0] val);
    @(negedge clk_100MHz);
    o_Rx_Four_Bytes = {op, 12'h000, val};
    o_Rx_DV = 1'b1;
    period_tick = 1'b1;
    @(negedge clk_100MHz);
    o_Rx_DV = 1'b0;
    period_tick = 1'b0;
    repeat (3) @(negedge clk_100MHz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int u0;
    logic [15:0] sweep_seq [8];
    sweep_seq = '{16'd1246, 16'd1249, 16'd1252, 16'd1253,
                  16'd1250, 16'd1247, 16'd1246, 16'd1249};
    RSTN = 1'b0;
    o_Rx_Four_Bytes = '0;
    o_Rx_DV = 1'b0;
    period_tick = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    chk("rst_div", 32'(freq_divider), 32'd1250);
    chk("rst_upd", 32'(div_update), 32'd0);
    chk("rst_active", 32'(sweep_active), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    RSTN = 1'b1;
    repeat (2) @(negedge clk_100MHz);

    // PRESET 1 applies only at the tick
    send(4'h2, 16'd1);
    chk("pre_tick_div", 32'(freq_divider), 32'd1250);
    chk("pre_tick_upd", 32'(upd_cnt), 32'd0);
    exp_q.push_back(16'd1253);
    tick();
    chk("preset_upd_cnt", 32'(upd_cnt), 32'd1);
    chk("preset_div", 32'(freq_divider), 32'd1253);

    // bad START (min > max) and zero STEP
    send(4'h3, 16'd1300);
    send(4'h4, 16'd1200);
    chk("cfg_no_err", 32'(err_cnt), 32'd0);
    send(4'h7, 16'd0);
    chk("bad_start_err", 32'(err_cnt), 32'd1);
    chk("bad_start_idle", 32'(sweep_active), 32'd0);
    send(4'h5, 16'd0);
    chk("step0_err", 32'(err_cnt), 32'd2);
    tick();
    chk("bad_start_noupd", 32'(upd_cnt), 32'd1);
    chk("bad_start_div", 32'(freq_divider), 32'd1253);

    // triangle sweep with clamp at both ends
    send(4'h3, 16'd1246);
    send(4'h4, 16'd1253);
    send(4'h5, 16'd3);
    send(4'h6, 16'd2);
    for (int i = 0; i < 8; i++) exp_q.push_back(sweep_seq[i]);
    send(4'h7, 16'd0);
    chk("sweep_active", 32'(sweep_active), 32'd1);
    u0 = upd_cnt;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("sweep_upd_cnt", 32'(upd_cnt), 32'(u0 + (i + 1) / 2));
    end
    chk("sweep_q_empty", 32'(exp_q.size()), 32'd0);
    chk("sweep_last_div", 32'(freq_divider), 32'd1249);

    // STOP on the dwell-expiry tick: no step staged
    send_tick(4'h8, 16'd0);
    chk("stop_inactive", 32'(sweep_active), 32'd0);
    u0 = upd_cnt;
    tick();
    tick();
    chk("stop_noupd", 32'(upd_cnt), 32'(u0));
    chk("stop_hold_div", 32'(freq_divider), 32'd1249);

    // last staged value wins
    send(4'h1, 16'd1400);
    send(4'h1, 16'd1500);
    chk("set_no_early", 32'(freq_divider), 32'd1249);
    exp_q.push_back(16'd1500);
    tick();
    chk("set_single_upd", 32'(upd_cnt), 32'(u0 + 1));
    chk("set_div", 32'(freq_divider), 32'd1500);

    // command coinciding with an apply waits for the following tick
    send(4'h1, 16'd1600);
    exp_q.push_back(16'd1600);
    exp_q.push_back(16'd1700);
    send_tick(4'h1, 16'd1700);
    chk("coincide_first", 32'(freq_divider), 32'd1600);
    tick();
    chk("coincide_second", 32'(freq_divider), 32'd1700);

    // equal value still pulses; preset table
    u0 = upd_cnt;
    send(4'h1, 16'd1700);
    exp_q.push_back(16'd1700);
    tick();
    chk("equal_upd", 32'(upd_cnt), 32'(u0 + 1));
    send(4'h2, 16'd3); exp_q.push_back(16'd1246); tick();
    send(4'h2, 16'd2); exp_q.push_back(16'd1250); tick();
    send(4'h2, 16'd9); exp_q.push_back(16'd1250); tick();
    chk("preset_q_empty", 32'(exp_q.size()), 32'd0);

    // illegal opcodes and SET 0
    send(4'hF, 16'd5);
    send(4'h0, 16'd5);
    chk("bad_op_err", 32'(err_cnt), 32'd4);
    u0 = upd_cnt;
    send(4'h1, 16'd0);
    tick();
    chk("set0_err", 32'(err_cnt), 32'd5);
    chk("set0_noupd", 32'(upd_cnt), 32'(u0));

    // reset mid-sweep, config back to defaults
    send(4'h3, 16'd1248);
    exp_q.push_back(16'd1248);
    exp_q.push_back(16'd1251);
    send(4'h7, 16'd0);
    tick();
    tick();
    tick();
    chk("pre_rst_div", 32'(freq_divider), 32'd1251);
    @(negedge clk_100MHz);
    RSTN = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    chk("midrst_div", 32'(freq_divider), 32'd1250);
    chk("midrst_active", 32'(sweep_active), 32'd0);
    chk("midrst_upd", 32'(div_update), 32'd0);
    chk("midrst_err", 32'(cmd_err), 32'd0);
    u0 = upd_cnt;
    RSTN = 1'b1;
    repeat (5) @(negedge clk_100MHz);
    chk("release_noupd", 32'(upd_cnt), 32'(u0));
    exp_q.push_back(16'd1246);
    send(4'h7, 16'd0);
    tick();
    chk("default_min_div", 32'(freq_divider), 32'd1246);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
